// File: rtl/uart_frame_ctrl_if.sv
// Byte-side and storage-side signal bundle for uart_frame_ctrl.
// The master modport is the controller's view; the slave modport is the environment's view.
interface uart_frame_ctrl_if #(
  parameter int MAX_N  = 8,
  parameter int DATA_W = 16
);
  localparam int AW = (MAX_N > 1) ? $clog2(MAX_N * MAX_N) : 1;
  localparam int NW = $clog2(MAX_N + 1);

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_pop;
  logic              mat_we;
  logic              vec_we;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NW-1:0]     n_cfg;
  logic              start;
  logic              busy;
  logic [3:0]        err;
  logic              err_clr;

  modport master (
    input  rx_valid, rx_data, tx_ready, fifo_empty, fifo_data, err_clr,
    output tx_valid, tx_data, fifo_pop, mat_we, vec_we, wr_addr, wr_data,
           n_cfg, start, busy, err
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, fifo_empty, fifo_data, err_clr,
    input  tx_valid, tx_data, fifo_pop, mat_we, vec_we, wr_addr, wr_data,
           n_cfg, start, busy, err
  );
endinterface

// File: rtl/uart_frame_ctrl.sv
// UART command-frame parser/responder: write strobes one cycle after a word's last byte;
// TX bytes held until tx_ready, response stalls (tx_valid=0) while the result FIFO is empty.
module uart_frame_ctrl #(
  parameter int MAX_N       = 8,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input logic               clk,
  input logic               reset,
  uart_frame_ctrl_if.master bus
);
  localparam int B  = DATA_W / 8;
  localparam int AW = (MAX_N > 1) ? $clog2(MAX_N * MAX_N) : 1;
  localparam int NW = $clog2(MAX_N + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN, S_CMD, S_PAYLOAD, S_EOF,
    S_TX_FE, S_TX_LEN, S_TX_CMD, S_TX_DATA, S_TX_EF
  } state_t;

  state_t            state, state_d;
  logic [7:0]        len_q, cmd_q, p_q, pay_cnt;
  logic [1:0]        bcnt;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              mat_we, vec_we, start, fifo_pop, n_ok;
  logic [NW-1:0]     n_cfg, n_new, word_cnt;
  logic [3:0]        err, err_set;
  logic [TW-1:0]     tout;

  logic       cmd_known, rx_state, timeout, n_good, tx_valid, tx_fire, last_byte;
  logic [8:0] p_calc;
  logic [7:0] tx_data;

  assign rx_state  = (state == S_LEN) || (state == S_CMD) || (state == S_PAYLOAD) || (state == S_EOF);
  assign timeout   = rx_state && !bus.rx_valid && (tout == TW'(TIMEOUT_CYC - 1));
  assign n_good    = (bus.rx_data != 8'd0) && (bus.rx_data <= 8'(MAX_N));
  assign last_byte = (bcnt == 2'(B - 1));

  always_comb begin
    cmd_known = 1'b1;
    p_calc    = '0;
    case (bus.rx_data)
      8'h01:        p_calc = 9'd1;
      8'h02, 8'h03: p_calc = 9'd0;
      8'h04:        p_calc = 9'(n_cfg * n_cfg * B);
      8'h05:        p_calc = 9'(n_cfg * B);
      default:      cmd_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    err_set  = 4'b0000;
    state_d  = state;
    case (state)
      S_TX_FE:   begin tx_valid = 1'b1; tx_data = 8'hFE; end
      S_TX_LEN:  begin tx_valid = 1'b1; tx_data = 8'(n_cfg * B + 1); end
      S_TX_CMD:  begin tx_valid = 1'b1; tx_data = 8'h02; end
      // head word is stale while the pop is in flight
      S_TX_DATA: begin
        tx_valid = !bus.fifo_empty && !fifo_pop;
        tx_data  = bus.fifo_data[8*(B-1-int'(bcnt)) +: 8];
      end
      S_TX_EF:   begin tx_valid = 1'b1; tx_data = 8'hEF; end
      default:   ;
    endcase
    tx_fire = tx_valid && bus.tx_ready;

    case (state)
      S_IDLE:    if (bus.rx_valid && bus.rx_data == 8'hFE) state_d = S_LEN;
      S_LEN:     if (bus.rx_valid) state_d = S_CMD;
      S_CMD: if (bus.rx_valid) begin
        if (!cmd_known) begin
          err_set[3] = 1'b1;
          state_d    = S_IDLE;
        end else if ({1'b0, len_q} != p_calc + 9'd1) begin
          err_set[0] = 1'b1;
          state_d    = S_IDLE;
        end else if (p_calc == 9'd0) begin
          state_d = S_EOF;
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (bus.rx_valid) begin
        if (cmd_q == 8'h01 && !n_good) err_set[0] = 1'b1;
        if (pay_cnt == p_q - 8'd1) state_d = S_EOF;
      end
      S_EOF: if (bus.rx_valid) begin
        if (bus.rx_data != 8'hEF) begin
          err_set[1] = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = (cmd_q == 8'h02) ? S_TX_FE : S_IDLE;
        end
      end
      S_TX_FE:   if (tx_fire) state_d = S_TX_LEN;
      S_TX_LEN:  if (tx_fire) state_d = S_TX_CMD;
      S_TX_CMD:  if (tx_fire) state_d = S_TX_DATA;
      S_TX_DATA: if (tx_fire && last_byte && word_cnt == n_cfg - 1'b1) state_d = S_TX_EF;
      S_TX_EF:   if (tx_fire) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (timeout) begin
      err_set[2] = 1'b1;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q    <= '0;
      cmd_q    <= '0;
      p_q      <= '0;
      pay_cnt  <= '0;
      bcnt     <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      mat_we   <= 1'b0;
      vec_we   <= 1'b0;
      start    <= 1'b0;
      fifo_pop <= 1'b0;
      n_ok     <= 1'b0;
      n_new    <= '0;
      n_cfg    <= NW'(MAX_N);
      word_cnt <= '0;
      err      <= '0;
      tout     <= '0;
    end else begin
      mat_we   <= 1'b0;
      vec_we   <= 1'b0;
      start    <= 1'b0;
      fifo_pop <= 1'b0;
      err      <= (bus.err_clr ? 4'b0000 : err) | err_set;
      tout     <= (rx_state && !bus.rx_valid) ? tout + 1'b1 : '0;
      if (mat_we || vec_we) wr_addr <= wr_addr + 1'b1;

      case (state)
        S_IDLE: if (bus.rx_valid && bus.rx_data == 8'hFE) begin
          wr_addr <= '0;
          bcnt    <= '0;
          pay_cnt <= '0;
        end
        S_LEN: if (bus.rx_valid) len_q <= bus.rx_data;
        S_CMD: if (bus.rx_valid) begin
          cmd_q <= bus.rx_data;
          p_q   <= p_calc[7:0];
          n_ok  <= 1'b0;
        end
        S_PAYLOAD: if (bus.rx_valid) begin
          pay_cnt <= pay_cnt + 8'd1;
          if (cmd_q == 8'h04 || cmd_q == 8'h05) begin
            wr_data <= (wr_data << 8) | DATA_W'(bus.rx_data);
            if (last_byte) begin
              bcnt   <= '0;
              mat_we <= (cmd_q == 8'h04);
              vec_we <= (cmd_q == 8'h05);
            end else begin
              bcnt <= bcnt + 2'd1;
            end
          end
          if (cmd_q == 8'h01) begin
            n_new <= NW'(bus.rx_data);
            n_ok  <= n_good;
          end
        end
        S_EOF: if (bus.rx_valid && bus.rx_data == 8'hEF) begin
          if (cmd_q == 8'h01 && n_ok) n_cfg <= n_new;
          if (cmd_q == 8'h03) start <= 1'b1;
          if (cmd_q == 8'h02) begin
            bcnt     <= '0;
            word_cnt <= '0;
          end
        end
        S_TX_DATA: if (tx_fire) begin
          if (last_byte) begin
            bcnt     <= '0;
            fifo_pop <= 1'b1;
            word_cnt <= word_cnt + 1'b1;
          end else begin
            bcnt <= bcnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tx_valid = tx_valid;
  assign bus.tx_data  = tx_data;
  assign bus.fifo_pop = fifo_pop;
  assign bus.mat_we   = mat_we;
  assign bus.vec_we   = vec_we;
  assign bus.wr_addr  = wr_addr;
  assign bus.wr_data  = wr_data;
  assign bus.n_cfg    = n_cfg;
  assign bus.start    = start;
  assign bus.busy     = (state != S_IDLE);
  assign bus.err      = err;
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Scoreboard bench for uart_frame_ctrl: directed frames, expected writes/TX bytes queued, negedge monitor compares.
module tb_uart_frame_ctrl;
  localparam int MAX_N = 8;
  localparam int DATA_W = 16;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_frame_ctrl_if #(.MAX_N(MAX_N), .DATA_W(DATA_W)) bus ();
  uart_frame_ctrl #(.MAX_N(MAX_N), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;
  int pop_cnt = 0;
  int rdy_mode = 0;  // 0 always ready, 1 toggling, 2 never ready
  logic [31:0] exp_wr[$];
  logic [7:0] exp_tx[$];
  logic [DATA_W-1:0] fifo_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a TX transfer
  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (bus.mat_we || bus.vec_we) begin
        if (exp_wr.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_wr: got addr %0h data %0h", bus.wr_addr, bus.wr_data);
        end else
          chk("wr", {8'h0, bus.vec_we, bus.mat_we, bus.wr_addr, bus.wr_data}, exp_wr.pop_front());
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_tx.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_tx: got %0h", bus.tx_data);
        end else
          chk("tx_byte", {24'h0, bus.tx_data}, {24'h0, exp_tx.pop_front()});
      end
      if (bus.start) start_cnt++;
      if (bus.fifo_pop) pop_cnt++;
    end
  end

  // Result FIFO model (first-word-fall-through)
  initial begin
    logic p;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;
    forever begin
      @(negedge clk);
      p = bus.fifo_pop;
      @(posedge clk); #1;
      if (p && fifo_q.size() > 0) void'(fifo_q.pop_front());
      bus.fifo_empty = (fifo_q.size() == 0);
      bus.fifo_data  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    end
  end

  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.tx_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ~bus.tx_ready : 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick(1);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [127:0] f, input int n);
    for (int i = 0; i < n; i++) send(f[8*(n-1-i) +: 8]);
  endtask

  task automatic push_tx(input logic [127:0] f, input int n);
    for (int i = 0; i < n; i++) exp_tx.push_back(f[8*(n-1-i) +: 8]);
  endtask

  task automatic push_wr(input logic mat, input int addr, input logic [DATA_W-1:0] d);
    exp_wr.push_back({8'h0, ~mat, mat, 6'(addr), d});
  endtask

  task automatic clear_err();
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400 && bus.busy; i++) tick(1);
    chk(name, {31'h0, bus.busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.err_clr  = 1'b0;
    tick(3);
    chk("rst_n_cfg",   32'(bus.n_cfg), 32'd8);
    chk("rst_err",     32'(bus.err), 32'h0);
    chk("rst_busy",    {31'h0, bus.busy}, 32'h0);
    chk("rst_tx_valid",{31'h0, bus.tx_valid}, 32'h0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'h0);
    chk("rst_wr",      {bus.mat_we, bus.vec_we, bus.start, bus.fifo_pop, 6'(bus.wr_addr), bus.wr_data}, 32'h0);
    reset = 1'b1;
    tick(2);

    // Set N=4: n_cfg moves only after the EOF byte
    send_frame({8'hFE, 8'h02, 8'h01, 8'h04}, 4);
    chk("n_before_eof", 32'(bus.n_cfg), 32'd8);
    send(8'hEF);
    chk("n_set4", 32'(bus.n_cfg), 32'd4);
    chk("err_ok", 32'(bus.err), 32'h0);

    // N=2 matrix and vector loads
    send_frame({8'hFE, 8'h02, 8'h01, 8'h02, 8'hEF}, 5);
    chk("n_set2", 32'(bus.n_cfg), 32'd2);
    push_wr(1, 0, 16'h0011); push_wr(1, 1, 16'h0022);
    push_wr(1, 2, 16'h0033); push_wr(1, 3, 16'h0044);
    send_frame({8'hFE, 8'h09, 8'h04, 8'h00, 8'h11, 8'h00, 8'h22, 8'h00, 8'h33, 8'h00, 8'h44, 8'hEF}, 12);
    tick(3);
    chk("mat_writes_done", 32'(exp_wr.size()), 32'd0);
    push_wr(0, 0, 16'h00AA); push_wr(0, 1, 16'h00BB);
    send_frame({8'hFE, 8'h05, 8'h05, 8'h00, 8'hAA, 8'h00, 8'hBB, 8'hEF}, 8);
    tick(3);
    chk("vec_writes_done", 32'(exp_wr.size()), 32'd0);

    // Read result, always ready
    fifo_q.push_back(16'hABCD); fifo_q.push_back(16'h1234);
    push_tx({8'hFE, 8'h05, 8'h02, 8'hAB, 8'hCD, 8'h12, 8'h34, 8'hEF}, 8);
    s0 = pop_cnt;
    send_frame({8'hFE, 8'h01, 8'h02, 8'hEF}, 4);
    wait_idle("tx1_done");
    tick(2);
    chk("tx1_bytes_left", 32'(exp_tx.size()), 32'd0);
    chk("tx1_pops", 32'(pop_cnt - s0), 32'd2);

    // Read result with toggling tx_ready; FIFO filled only after the header goes out
    rdy_mode = 1;
    push_tx({8'hFE, 8'h05, 8'h02, 8'hAB, 8'hCD, 8'h12, 8'h34, 8'hEF}, 8);
    s0 = pop_cnt;
    send_frame({8'hFE, 8'h01, 8'h02, 8'hEF}, 4);
    tick(12);
    chk("tx2_stall_empty", 32'(exp_tx.size()), 32'd5);
    chk("tx2_valid_low", {31'h0, bus.tx_valid}, 32'h0);
    fifo_q.push_back(16'hABCD); fifo_q.push_back(16'h1234);
    wait_idle("tx2_done");
    tick(2);
    chk("tx2_bytes_left", 32'(exp_tx.size()), 32'd0);
    chk("tx2_pops", 32'(pop_cnt - s0), 32'd2);
    rdy_mode = 0;

    // Wrong LEN for matrix load, then a start that keeps the sticky error
    send_frame({8'hFE, 8'h05, 8'h04, 8'hEF}, 4);
    tick(2);
    chk("badlen_err", 32'(bus.err), 32'h1);
    chk("badlen_idle", {31'h0, bus.busy}, 32'h0);
    s0 = start_cnt;
    send_frame({8'hFE, 8'h01, 8'h03, 8'hEF}, 4);
    tick(3);
    chk("start_once", 32'(start_cnt - s0), 32'd1);
    chk("err_sticky", 32'(bus.err), 32'h1);

    // Bad EOF with err_clr in the same cycle: the set wins, old bit clears
    s0 = start_cnt;
    send_frame({8'hFE, 8'h01, 8'h03}, 3);
    bus.err_clr = 1'b1;
    send(8'hAA);
    bus.err_clr = 1'b0;
    tick(2);
    chk("bad_eof_err", 32'(bus.err), 32'h2);
    chk("bad_eof_nostart", 32'(start_cnt - s0), 32'd0);
    clear_err();
    chk("err_cleared", 32'(bus.err), 32'h0);

    // Set N out of range, then the largest legal value
    send_frame({8'hFE, 8'h02, 8'h01, 8'h09, 8'hEF}, 5);
    tick(1);
    chk("badn_err", 32'(bus.err), 32'h1);
    chk("badn_keep", 32'(bus.n_cfg), 32'd2);
    clear_err();
    send_frame({8'hFE, 8'h02, 8'h01, 8'h08, 8'hEF}, 5);
    chk("n_set8", 32'(bus.n_cfg), 32'd8);
    chk("n8_err", 32'(bus.err), 32'h0);

    // Unknown command
    send_frame({8'hFE, 8'h01, 8'h07, 8'hEF}, 4);
    tick(1);
    chk("unk_cmd_err", 32'(bus.err), 32'h8);
    clear_err();

    // RX timeout after FE 03
    send_frame({8'hFE, 8'h03}, 2);
    tick(TMO - 2);
    chk("tmo_not_yet", {27'h0, bus.busy, bus.err}, {27'h0, 1'b1, 4'h0});
    tick(3);
    chk("tmo_err", 32'(bus.err), 32'h4);
    chk("tmo_idle", {31'h0, bus.busy}, 32'h0);
    clear_err();

    // Reset in the middle of a stalled response
    send_frame({8'hFE, 8'h02, 8'h01, 8'h03, 8'hEF}, 5);
    chk("n_set3", 32'(bus.n_cfg), 32'd3);
    rdy_mode = 2;
    tick(1);
    send_frame({8'hFE, 8'h01, 8'h02, 8'hEF}, 4);
    tick(2);
    chk("resp_stalled", {30'h0, bus.busy, bus.tx_valid}, 32'h3);
    reset = 1'b0;
    #1;
    chk("rst_mid_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    chk("rst_mid_n_cfg", 32'(bus.n_cfg), 32'd8);
    chk("rst_mid_busy", {31'h0, bus.busy}, 32'h0);
    tick(2);
    reset = 1'b1;
    rdy_mode = 0;
    tick(2);
    chk("final_exp_wr", 32'(exp_wr.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
